majority_vote_collector: RTL and testbench

Serial front end for the 5-input majority voter. It collects five single-bit votes over a valid/ready handshake and assembles them into a 5-bit vector. It computes the popcount and majority decision, then presents the registered result downstream over a second valid/ready handshake. A per-round inactivity timeout closes incomplete rounds, so a stalled source cannot hang the pipeline.

---
 rtl/majority_vote_collector_if.sv | 20 ++
 rtl/majority_vote_collector.sv | 59 +++++
 tb/tb_majority_vote_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/majority_vote_collector_if.sv
// majority_vote_collector_if: vote input and result output handshakes of the majority vote collector.
interface majority_vote_collector_if;
    logic       vote_valid;
    logic       vote;
    logic       vote_ready;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_votes;
    logic [2:0] res_ones;
    logic       res_major;
    logic       res_timeout;
    modport slave (
        input  vote_valid, vote, res_ready,
        output vote_ready, res_valid, res_votes, res_ones, res_major, res_timeout
    );
    modport master (
        output vote_valid, vote, res_ready,
        input  vote_ready, res_valid, res_votes, res_ones, res_major, res_timeout
    );
endinterface

// File: rtl/majority_vote_collector.sv
// majority_vote_collector: gathers five serial votes into a vector and presents
// popcount and majority with an inactivity timeout per round.
module majority_vote_collector #(
    parameter  int TIMEOUT = 15,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input logic clk,
    input logic rst,
    majority_vote_collector_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    votes_q, votes_d;
    logic [2:0]    ones_q, ones_d;
    logic          major_q, major_d, tout_q, tout_d;
    logic          vote_acc, res_acc, last, expire, close;
    always_comb begin
        vote_acc = bus.vote_valid && state_q != DONE;
        res_acc  = bus.res_ready && state_q == DONE;
        last     = vote_acc && idx_q == 3'd4;
        // Idle-cycle expiry loses to a vote arriving on the same edge.
        expire   = state_q == COLLECT && !vote_acc && timer_q == TW'(TIMEOUT - 1);
        close    = last || expire;
        state_d  = res_acc ? IDLE : close ? DONE : vote_acc ? COLLECT : state_q;
        idx_d    = res_acc ? 3'd0 : vote_acc ? idx_q + 3'd1 : idx_q;
        timer_d  = (vote_acc || state_q != COLLECT) ? '0 : timer_q + 1'b1;
        votes_d  = res_acc ? 5'd0 : vote_acc ? votes_q | (5'({bus.vote}) << idx_q) : votes_q;
        ones_d   = 3'(votes_d[0]) + 3'(votes_d[1]) + 3'(votes_d[2]) + 3'(votes_d[3]) + 3'(votes_d[4]);
        major_d  = ones_d >= 3'd3;
        tout_d   = res_acc ? 1'b0 : close ? expire : tout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            votes_q <= '0;
            ones_q  <= '0;
            major_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            votes_q <= votes_d;
            ones_q  <= ones_d;
            major_q <= major_d;
            tout_q  <= tout_d;
        end
    end
    assign bus.vote_ready  = state_q != DONE;
    assign bus.res_valid   = state_q == DONE;
    assign bus.res_votes   = votes_q;
    assign bus.res_ones    = ones_q;
    assign bus.res_major   = major_q;
    assign bus.res_timeout = tout_q;
endmodule

// File: tb/tb_majority_vote_collector.sv
// tb_majority_vote_collector: randomized rounds checked against a per-round vote/gap model.
module tb_majority_vote_collector;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int gaps[5];
    majority_vote_collector_if bus();
    majority_vote_collector #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [11:0] obs();
        return {bus.res_valid, bus.vote_ready, bus.res_votes, bus.res_ones, bus.res_major, bus.res_timeout};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // gaps[i] idle cycles precede vote i; TO or more idle cycles after the first vote end the round.
    task automatic run_round(input logic [4:0] v, input int stall, input bit rdy);
        logic [4:0] ev = '0;
        bit to = 1'b0;
        int ones = 0;
        bus.res_ready = rdy;
        for (int i = 0; i < 5 && !to; i++) begin
            for (int j = 1; j <= gaps[i]; j++) begin
                @(negedge clk);
                bus.vote_valid = 1'b0;
                bus.vote = 1'($urandom);
                tick();
                if (i > 0 && j == TO) begin
                    to = 1'b1;
                    break;
                end
                check("idle", 32'(bus.res_valid), 32'd0);
            end
            if (!to) begin
                @(negedge clk);
                bus.vote_valid = 1'b1;
                bus.vote = v[i];
                tick();
                ev[i] = v[i];
                if (i < 4) check("collect", 32'({bus.res_valid, bus.vote_ready}), 32'b01);
            end
        end
        for (int i = 0; i < 5; i++) ones += int'(ev[i]);
        check("done", 32'(obs()), 32'({1'b1, 1'b0, ev, 3'(ones), ones >= 3, to}));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            bus.res_ready = 1'b0;
            bus.vote_valid = 1'($urandom);
            bus.vote = 1'($urandom);
            tick();
            check("hold", 32'(obs()), 32'({1'b1, 1'b0, ev, 3'(ones), ones >= 3, to}));
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.vote_valid = 1'b0;
        tick();
        check("release", 32'({bus.res_valid, bus.vote_ready, bus.res_votes}), 32'b01_00000);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask
    initial begin
        bus.vote_valid = 1'b0;
        bus.vote = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        check("reset", 32'(obs()), 32'({1'b0, 1'b1, 10'd0}));
        @(negedge clk);
        rst = 1'b0;
        gaps = '{0, 0, 0, 0, 0};
        run_round(5'b01011, 0, 1'b1);
        run_round(5'b10110, 10, 1'b0);
        gaps = '{0, 0, TO, 0, 0};
        run_round(5'b11011, 2, 1'b0);
        gaps = '{10, TO - 1, TO - 1, TO - 1, TO - 1};
        run_round(5'b10101, 1, 1'b0);
        gaps = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.vote_valid = 1'b1;
            bus.vote = 1'b1;
            tick();
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("midreset", 32'(obs()), 32'({1'b0, 1'b1, 10'd0}));
        @(negedge clk);
        rst = 1'b0;
        bus.vote_valid = 1'b0;
        run_round(5'b11100, 0, 1'b0);
        for (int p = 0; p < 32; p++) begin
            foreach (gaps[k]) gaps[k] = int'($urandom_range(0, TO - 1));
            run_round(5'(p), int'($urandom_range(0, 3)), 1'($urandom));
        end
        for (int r = 0; r < 12; r++) begin
            foreach (gaps[k]) gaps[k] = int'($urandom_range(0, TO + 1));
            run_round(5'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
